// File: rtl/score_encoder.sv
// Score encoder: turns each stored symbol index into a VEC_LEN-entry score vector with the peak at the index.
// Optional feature macro NOISE_EN: replaces the constant background with 7-bit LFSR noise.
module score_encoder #(
  parameter int         TOTAL_VAL = 10,
  parameter int         VEC_LEN   = 32,
  parameter logic [7:0] PEAK      = 8'd255,
  parameter logic [7:0] BG        = 8'd0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  output logic        finish,
  output logic [9:0]  idx_addr,
  input  logic [7:0]  idx_q,
  output logic [14:0] score_addr,
  output logic [7:0]  score_data,
  output logic        score_wren
);

  localparam int SYM_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE,
    START,
    RD_IDX,
    RD_WAIT1,
    RD_WAIT2,
    LATCH,
    WR_VEC,
    NEXT,
    FINISH
  } state_t;

  state_t           state_reg;
  logic [9:0]       i_reg;
  logic [SYM_W-1:0] j_reg;
  logic [SYM_W-1:0] sym_reg;
  logic [14:0]      w_base_reg;
  logic [7:0]       bg_value;

  // Only the low SYM_W index bits select a position; the rest are dropped.
  logic unused_idx_bits;
  assign unused_idx_bits = &{1'b0, idx_q};

`ifdef NOISE_EN
  logic [7:0] lfsr_reg;
  logic [7:0] lfsr_next;
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  assign lfsr_next = {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? 8'hB8 : 8'h00);
  assign bg_value  = {1'b0, lfsr_reg[6:0]};
`else
  assign bg_value  = BG;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      finish     <= 1'b0;
      score_wren <= 1'b0;
      idx_addr   <= '0;
      score_addr <= '0;
      score_data <= '0;
      i_reg      <= '0;
      j_reg      <= '0;
      sym_reg    <= '0;
      w_base_reg <= '0;
`ifdef NOISE_EN
      lfsr_reg   <= 8'hA5;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) state_reg <= START;
        end
        START: begin
          finish     <= 1'b0;
          i_reg      <= '0;
          w_base_reg <= '0;
`ifdef NOISE_EN
          lfsr_reg   <= 8'hA5;
`endif
          state_reg  <= RD_IDX;
        end
        RD_IDX: begin
          idx_addr  <= i_reg;
          state_reg <= RD_WAIT1;
        end
        RD_WAIT1: state_reg <= RD_WAIT2;
        RD_WAIT2: state_reg <= LATCH;
        LATCH: begin
          sym_reg   <= idx_q[SYM_W-1:0];
          j_reg     <= '0;
          state_reg <= WR_VEC;
        end
        WR_VEC: begin
          // Outputs are registered, so the RAM commits each entry one cycle later.
          score_wren <= 1'b1;
          score_addr <= w_base_reg + 15'(j_reg);
          score_data <= (j_reg == sym_reg) ? PEAK : bg_value;
          j_reg      <= j_reg + SYM_W'(1);
`ifdef NOISE_EN
          lfsr_reg   <= lfsr_next;
`endif
          if (j_reg == SYM_W'(VEC_LEN - 1)) state_reg <= NEXT;
        end
        NEXT: begin
          score_wren <= 1'b0;
          w_base_reg <= w_base_reg + 15'(VEC_LEN);
          i_reg      <= i_reg + 10'd1;
          state_reg  <= (i_reg == 10'(TOTAL_VAL - 1)) ? FINISH : RD_IDX;
        end
        FINISH: begin
          finish    <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_encoder.sv
// Directed bench for score_encoder: scoreboard of expected RAM writes plus full-image checks.
module tb_score_encoder;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic        finish;
  logic [9:0]  idx_addr;
  logic [7:0]  idx_q;
  logic [14:0] score_addr;
  logic [7:0]  score_data;
  logic        score_wren;

  always #10 CLOCK_50 = ~CLOCK_50;

  score_encoder dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .start      (start),
    .finish     (finish),
    .idx_addr   (idx_addr),
    .idx_q      (idx_q),
    .score_addr (score_addr),
    .score_data (score_data),
    .score_wren (score_wren)
  );

  logic [7:0] idx_mem   [1024];
  logic [7:0] score_mem [32768];
  bit         written   [32768];
  logic [7:0] exp_img   [320];

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;

  always @(posedge CLOCK_50) idx_q <= idx_mem[idx_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Score RAM model and write scoreboard; a write is presented for the following rising edge.
  always @(negedge CLOCK_50) begin
    if (!reset && score_wren === 1'b1) begin
      wr_t e;
      wr_cnt++;
      score_mem[score_addr] <= score_data;
      written[score_addr]   <= 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {17'b0, score_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {17'b0, score_addr}, {17'b0, e.addr});
        chk("wr_data", {24'b0, score_data}, {24'b0, e.data});
      end
    end
  end

  task automatic push_run();
    logic [7:0] lf;
    logic [7:0] bg;
    logic [7:0] d;
    logic [7:0] v;
    logic [4:0] sym;
    wr_t        e;
    lf = 8'hA5;
    for (int k = 0; k < 10; k++) begin
      v   = idx_mem[k];
      sym = v[4:0];
      for (int j = 0; j < 32; j++) begin
`ifdef NOISE_EN
        bg = {1'b0, lf[6:0]};
        lf = {1'b0, lf[7:1]} ^ (lf[0] ? 8'hB8 : 8'h00);
`else
        bg = 8'd0;
`endif
        d = (j == int'(sym)) ? 8'd255 : bg;
        e.addr = 15'(k * 32 + j);
        e.data = d;
        exp_q.push_back(e);
        exp_img[k * 32 + j] = d;
      end
    end
  endtask

  task automatic check_image(input string tag);
    int outside;
    outside = 0;
    for (int a = 0; a < 320; a++) chk({tag, "_img"}, {24'b0, score_mem[a]}, {24'b0, exp_img[a]});
    for (int a = 320; a < 32768; a++) if (written[a]) outside++;
    chk({tag, "_writes_outside"}, outside, 0);
  endtask

  // Start a run and count cycles until finish rises (after having been seen low).
  task automatic run_and_wait(input bit hold, output int cyc);
    bit seen_low;
    seen_low = 1'b0;
    cyc      = 0;
    start    = 1'b1;
    while (cyc < 2000) begin
      @(posedge CLOCK_50);
      #1;
      cyc++;
      if (!hold) start = 1'b0;
      if (finish === 1'b0) seen_low = 1'b1;
      if (seen_low && finish === 1'b1) break;
    end
  endtask

  initial begin
    int cyc;
    int cyc2;
    int w0;
    for (int a = 0; a < 1024; a++) idx_mem[a] = 8'd0;
    for (int a = 0; a < 32768; a++) begin
      score_mem[a] = 8'd0;
      written[a]   = 1'b0;
    end

    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_finish", {31'b0, finish}, 0);
    chk("rst_wren", {31'b0, score_wren}, 0);
    chk("rst_idx_addr", {22'b0, idx_addr}, 0);
    chk("rst_score_addr", {17'b0, score_addr}, 0);
    chk("rst_score_data", {24'b0, score_data}, 0);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // Run 1: identity indices.
    for (int k = 0; k < 10; k++) idx_mem[k] = 8'(k);
    push_run();
    run_and_wait(1'b0, cyc);
    chk("run1_latency", cyc, 373);
    check_image("run1");
    chk("run1_peak33", {24'b0, score_mem[33]}, 32'd255);
    $display("run 1: identity indices, latency %0d cycles, %0d writes", cyc, wr_cnt);

    // Run 2: boundary indices 31/0 and out-of-range 40.
    idx_mem[0] = 8'd31;
    idx_mem[1] = 8'd0;
    idx_mem[2] = 8'd40;
    for (int k = 3; k < 10; k++) idx_mem[k] = 8'($urandom_range(0, 255));
    push_run();
    run_and_wait(1'b0, cyc);
    chk("run2_latency", cyc, 373);
    check_image("run2");
    chk("run2_peak31", {24'b0, score_mem[31]}, 32'd255);
    chk("run2_peak32", {24'b0, score_mem[32]}, 32'd255);
    chk("run2_peak72", {24'b0, score_mem[72]}, 32'd255);
    chk("run2_queue_empty", exp_q.size(), 0);
    $display("run 2: indices 31/0/40, latency %0d cycles", cyc);

    // Run 3: reset while vector 4 entry 10 is being presented.
    for (int k = 0; k < 10; k++) idx_mem[k] = 8'($urandom_range(0, 255));
    push_run();
    w0    = wr_cnt;
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    cyc   = 0;
    while (cyc < 1000) begin
      @(negedge CLOCK_50);
      cyc++;
      if (score_wren === 1'b1 && score_addr == 15'd137) break;
    end
    chk("run3_reach_addr137", cyc < 1000, 1);
    @(posedge CLOCK_50);
    #1;
    chk("run3_pre_reset_addr", {17'b0, score_addr}, 32'd138);
    #1;
    reset = 1'b1;
    #1;
    chk("run3_reset_wren", {31'b0, score_wren}, 0);
    chk("run3_reset_finish", {31'b0, finish}, 0);
    chk("run3_writes_before_reset", wr_cnt - w0, 138);
    chk("run3_pending_writes", exp_q.size(), 182);
    exp_q.delete();
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    push_run();
    run_and_wait(1'b0, cyc);
    chk("run3_restart_latency", cyc, 373);
    check_image("run3");
    $display("run 3: reset mid-vector after %0d writes, restart latency %0d", 138, cyc);

    // Run 4: a start pulse during WR_VEC must be ignored.
    for (int k = 0; k < 10; k++) idx_mem[k] = 8'($urandom_range(0, 255));
    push_run();
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    cyc   = 0;
    while (cyc < 100 && score_wren !== 1'b1) begin
      @(posedge CLOCK_50);
      #1;
      cyc++;
    end
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    cyc   = 0;
    while (cyc < 1000 && finish !== 1'b1) begin
      @(posedge CLOCK_50);
      #1;
      cyc++;
    end
    chk("run4_finish", {31'b0, finish}, 1);
    w0 = wr_cnt;
    repeat (60) @(posedge CLOCK_50);
    #1;
    chk("run4_no_extra_writes", wr_cnt - w0, 0);
    chk("run4_finish_holds", {31'b0, finish}, 1);
    chk("run4_queue_empty", exp_q.size(), 0);
    check_image("run4");
    $display("run 4: start pulse in WR_VEC ignored");

    // Runs 5/6: start held high gives two back-to-back runs.
    for (int k = 0; k < 10; k++) idx_mem[k] = 8'($urandom_range(0, 255));
    push_run();
    push_run();
    run_and_wait(1'b1, cyc);
    chk("run5_latency", cyc, 373);
    @(posedge CLOCK_50);
    #1;
    chk("run5_finish_in_idle", {31'b0, finish}, 1);
    @(posedge CLOCK_50);
    #1;
    chk("run6_finish_low_after_start", {31'b0, finish}, 0);
    start = 1'b0;
    cyc2  = 0;
    while (cyc2 < 1000 && finish !== 1'b1) begin
      @(posedge CLOCK_50);
      #1;
      cyc2++;
    end
    chk("run6_period", cyc2 + 2, 373);
    chk("run6_queue_empty", exp_q.size(), 0);
    check_image("run6");
    $display("runs 5/6: back-to-back with start held, period %0d cycles", cyc2 + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
